// File: rtl/coder_pkg.sv
// Shared types and helpers for the encoded-request strobe decoder.
package coder_pkg;

   typedef logic [1:0] code_t;

   localparam code_t CODE_A1 = 2'b00;
   localparam code_t CODE_A2 = 2'b01;
   localparam code_t CODE_A3 = 2'b10;
   localparam code_t CODE_A4 = 2'b11;

   typedef enum logic [1:0] {IDLE, HOLD, GAP} dec_state_t;

   // Result bit order is {a4,a3,a2,a1}.
   function automatic logic [3:0] code_to_onehot(input code_t code);
      logic [3:0] oh;
      oh = 4'b0000;
      case (code)
         CODE_A1: oh = 4'b0001;
         CODE_A2: oh = 4'b0010;
         CODE_A3: oh = 4'b0100;
         default: oh = 4'b1000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/priority_decoder_if.sv
// Code input handshake: {x,y} qualified by in_valid, throttled by in_ready.
interface priority_decoder_if;
   logic x;
   logic y;
   logic in_valid;
   logic in_ready;

   modport master (output x, output y, output in_valid, input in_ready);
   modport slave  (input x, input y, input in_valid, output in_ready);
endinterface

// File: rtl/code_fifo.sv
// Small synchronous FIFO of 2-bit codes; dout shows the head entry without a read cycle.
module code_fifo
   import coder_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  code_t       din,
   output code_t       dout,
   output logic [AW:0] count,
   output logic        full,
   output logic        empty
);

   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   code_t           mem [DEPTH];
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;
   logic            push_ok;
   logic            pop_ok;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem[rptr];

   // Storage is not reset; resetting the pointers is enough to discard its contents.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop_ok)  rptr <= rptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/priority_decoder.sv
// Replays buffered 2-bit codes as one-hot strobes on a1..a4, each held
// HOLD_CYCLES cycles and followed by a single idle cycle.
module priority_decoder
   import coder_pkg::*;
#(
   parameter int HOLD_CYCLES = 4,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   priority_decoder_if.slave            bus,
   output logic                         a1,
   output logic                         a2,
   output logic                         a3,
   output logic                         a4,
   output logic                         busy,
   output logic [$clog2(FIFO_DEPTH):0]  count
);

   localparam logic [7:0] HOLD_M1 = 8'(HOLD_CYCLES - 1);

   dec_state_t                   state;
   dec_state_t                   state_n;
   logic [7:0]                   hold_cnt;
   logic [7:0]                   hold_cnt_n;
   logic [3:0]                   onehot;
   logic [3:0]                   onehot_n;
   logic                         push;
   logic                         pop;
   logic                         full;
   logic                         empty;
   code_t                        head;
   logic [$clog2(FIFO_DEPTH):0]  count_n;

   assign bus.in_ready = ~full;
   assign push         = bus.in_valid & ~full;
   assign {a4, a3, a2, a1} = onehot;

   code_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   ({bus.x, bus.y}),
      .dout  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      state_n    = state;
      hold_cnt_n = hold_cnt;
      onehot_n   = onehot;
      pop        = 1'b0;
      case (state)
         // GAP shares the pop path with IDLE so back-to-back codes skip IDLE.
         IDLE, GAP: begin
            onehot_n = 4'b0000;
            if (!empty) begin
               pop        = 1'b1;
               onehot_n   = code_to_onehot(head);
               hold_cnt_n = HOLD_M1;
               state_n    = HOLD;
            end else begin
               state_n = IDLE;
            end
         end
         HOLD: begin
            if (hold_cnt == 8'd0) begin
               onehot_n = 4'b0000;
               state_n  = GAP;
            end else begin
               hold_cnt_n = hold_cnt - 8'd1;
            end
         end
         default: begin
            onehot_n = 4'b0000;
            state_n  = IDLE;
         end
      endcase
   end

   // Next occupancy, so busy is registered in step with state and count.
   always_comb begin
      count_n = count;
      case ({push, pop})
         2'b10:   count_n = count + 1'b1;
         2'b01:   count_n = count - 1'b1;
         default: count_n = count;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         hold_cnt <= 8'd0;
         onehot   <= 4'b0000;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         hold_cnt <= hold_cnt_n;
         onehot   <= onehot_n;
         busy     <= (state_n != IDLE) || (count_n != '0);
      end
   end

endmodule

// File: tb/tb_priority_decoder.sv
// Bench for priority_decoder: vector table, burst, overflow, async reset and HOLD_CYCLES=1 loop-back.
module tb_priority_decoder;

   localparam int H = 4;

   typedef struct {
      logic [1:0] code;
      logic [3:0] oh;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   priority_decoder_if bus0 ();
   priority_decoder_if bus1 ();

   logic       a1, a2, a3, a4, busy0;
   logic       b1, b2, b3, b4, busy1;
   logic [2:0] count0, count1;
   logic [3:0] oh0, oh1;
   assign oh0 = {a4, a3, a2, a1};
   assign oh1 = {b4, b3, b2, b1};

   priority_decoder #(.HOLD_CYCLES(H), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .bus(bus0),
      .a1(a1), .a2(a2), .a3(a3), .a4(a4), .busy(busy0), .count(count0)
   );

   priority_decoder #(.HOLD_CYCLES(1), .FIFO_DEPTH(4)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1),
      .a1(b1), .a2(b2), .a3(b3), .a4(b4), .busy(busy1), .count(count1)
   );

   int errors = 0;
   int checks = 0;
   int pulses = 0;
   logic [1:0] sb [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] exp_oh(input logic [1:0] c);
      case (c)
         2'b00:   return 4'b0001;
         2'b01:   return 4'b0010;
         2'b10:   return 4'b0100;
         default: return 4'b1000;
      endcase
   endfunction

   // Stand-in for the priority_coder feeding the loop-back test.
   function automatic logic [1:0] prio_enc(input logic [3:0] v);
      if (v[3])      return 2'b11;
      else if (v[2]) return 2'b10;
      else if (v[1]) return 2'b01;
      else           return 2'b00;
   endfunction

   // Scoreboard producer: every accepted code of the main instance.
   always @(posedge clk) begin
      if (!rst && bus0.in_valid && bus0.in_ready)
         sb.push_back({bus0.x, bus0.y});
   end

   logic [3:0] prev0 = 4'b0000;
   int         run0  = 0;

   // Scoreboard consumer plus one-hot invariant and pulse-length checks.
   always @(negedge clk) begin
      if (rst) begin
         prev0 <= 4'b0000;
         run0  <= 0;
      end else begin
         check("onehot0 invariant", 32'($countones(oh0) <= 1), 32'd1);
         check("onehot1 invariant", 32'($countones(oh1) <= 1), 32'd1);
         if (oh0 != 4'b0000 && prev0 == 4'b0000) begin
            if (sb.size() == 0) check("unexpected pulse", 32'(oh0), 32'd0);
            else begin
               check("scoreboard order", 32'(oh0), 32'(exp_oh(sb.pop_front())));
               pulses <= pulses + 1;
            end
         end
         if (oh0 != 4'b0000) run0 <= (prev0 == 4'b0000) ? 1 : run0 + 1;
         if (oh0 == 4'b0000 && prev0 != 4'b0000) check("pulse length", 32'(run0), 32'(H));
         prev0 <= oh0;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t       tab [4];
   logic [1:0] burst [4];
   logic [1:0] ovf [6];
   logic [3:0] stim [4];
   logic [3:0] e;
   logic [3:0] seen;
   int         p_before;
   int         i;

   initial begin
      tab[0] = '{2'b10, 4'b0100};
      tab[1] = '{2'b00, 4'b0001};
      tab[2] = '{2'b01, 4'b0010};
      tab[3] = '{2'b11, 4'b1000};
      burst  = '{2'b00, 2'b01, 2'b10, 2'b11};
      ovf    = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01};
      stim   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

      rst = 1'b1;
      bus0.x = 1'b0; bus0.y = 1'b0; bus0.in_valid = 1'b0;
      bus1.x = 1'b0; bus1.y = 1'b0; bus1.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset outputs", 32'(oh0), 32'd0);
      check("reset busy", 32'(busy0), 32'd0);
      check("reset count", 32'(count0), 32'd0);
      check("reset outputs dut1", 32'(oh1), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("in_ready after reset", 32'(bus0.in_ready), 32'd1);
      @(posedge clk); #1;

      // Single codes: latency, hold length, gap, busy fall.
      foreach (tab[v]) begin
         {bus0.x, bus0.y} = tab[v].code;
         bus0.in_valid = 1'b1;
         @(posedge clk); #1 bus0.in_valid = 1'b0;
         for (int k = 0; k <= H + 2; k++) begin
            @(negedge clk);
            e = (k >= 1 && k <= H) ? tab[v].oh : 4'b0000;
            check($sformatf("vec%0d out k=%0d", v, k), 32'(oh0), 32'(e));
            check($sformatf("vec%0d busy k=%0d", v, k), 32'(busy0), 32'(k <= H + 1));
            @(posedge clk); #1;
         end
      end

      // Burst of four: no stall, count peaks at 3, 20-cycle output train.
      for (int k = 0; k < 23; k++) begin
         if (k < 4) begin
            check($sformatf("burst ready k=%0d", k), 32'(bus0.in_ready), 32'd1);
            {bus0.x, bus0.y} = burst[k];
            bus0.in_valid = 1'b1;
         end else begin
            bus0.in_valid = 1'b0;
         end
         if (k == 4) check("burst count peak", 32'(count0), 32'd3);
         @(negedge clk);
         if (k >= 2) begin
            i = k - 2;
            e = (i < 20 && (i % 5) < 4) ? exp_oh(burst[i / 5]) : 4'b0000;
            check($sformatf("burst out i=%0d", i), 32'(oh0), 32'(e));
            if (i == 20) check("burst busy end", 32'(busy0), 32'd0);
         end
         @(posedge clk); #1;
      end

      // Overflow: the sixth code meets a full FIFO and is dropped.
      p_before = pulses;
      for (int k = 0; k < 6; k++) begin
         check($sformatf("ovf ready k=%0d", k), 32'(bus0.in_ready), 32'(k < 5));
         if (k == 5) check("ovf count full", 32'(count0), 32'd4);
         {bus0.x, bus0.y} = ovf[k];
         bus0.in_valid = 1'b1;
         @(posedge clk); #1;
      end
      bus0.in_valid = 1'b0;
      repeat (32) @(posedge clk);
      #1;
      check("ovf pulses emitted", 32'(pulses - p_before), 32'd5);
      check("ovf scoreboard drained", 32'(sb.size()), 32'd0);
      check("ovf idle", 32'(busy0), 32'd0);

      // Async reset during a2 hold with two codes queued.
      for (int k = 0; k < 3; k++) begin
         {bus0.x, bus0.y} = tab[k + 1].code + 2'd1;
         bus0.in_valid = 1'b1;
         @(posedge clk); #1;
      end
      bus0.in_valid = 1'b0;
      @(negedge clk);
      check("pre-reset a2 held", 32'(oh0), 32'b0010);
      check("pre-reset queued", 32'(count0), 32'd2);
      @(posedge clk); #2 rst = 1'b1;
      sb.delete();
      #1;
      check("async reset outputs", 32'(oh0), 32'd0);
      check("async reset count", 32'(count0), 32'd0);
      check("async reset busy", 32'(busy0), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      seen = 4'b0000;
      repeat (20) begin
         @(negedge clk);
         seen = seen | oh0;
      end
      check("post-reset silence", 32'(seen), 32'd0);
      check("post-reset count", 32'(count0), 32'd0);
      check("post-reset busy", 32'(busy0), 32'd0);
      @(posedge clk); #1;

      // HOLD_CYCLES=1 loop-back through the encoder model.
      for (int k = 0; k < 11; k++) begin
         if (k < 4) begin
            check($sformatf("loop ready k=%0d", k), 32'(bus1.in_ready), 32'd1);
            {bus1.x, bus1.y} = prio_enc(stim[k]);
            bus1.in_valid = 1'b1;
         end else begin
            bus1.in_valid = 1'b0;
         end
         @(negedge clk);
         if (k >= 2) begin
            i = k - 2;
            e = (i < 8 && (i % 2) == 0) ? stim[i / 2] : 4'b0000;
            check($sformatf("loop out i=%0d", i), 32'(oh1), 32'(e));
         end
         @(posedge clk); #1;
      end
      repeat (2) @(posedge clk);
      #1;
      check("loop busy end", 32'(busy1), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/priority_decoder.md
# priority_decoder

Sequential counterpart to `priority_coder`. It accepts 2-bit codes `{x,y}` over a valid/ready handshake and buffers them in a small FIFO. Each code is replayed as a one-hot pulse on `a1..a4`, held for a fixed number of cycles and followed by one all-zero gap cycle. The block converts encoded requests back into strobe lines for downstream logic and for loop-back checks against `priority_coder`.

## Interface
- `HOLD_CYCLES`, default 4: cycles each one-hot output stays high. Legal range is 1..255.
- `FIFO_DEPTH`, default 4: buffered codes. Must be a power of 2 and at least 2.
- `clk` input, 1: single clock, rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `x` input, 1: code MSB.
- `y` input, 1: code LSB.
- `in_valid` input, 1: the code on `{x,y}` is valid this cycle.
- `in_ready` output, 1: FIFO not full. A code is accepted when `in_valid & in_ready` at a rising edge.
- `a1` output, 1: one-hot output for code 00.
- `a2` output, 1: one-hot output for code 01.
- `a3` output, 1: one-hot output for code 10.
- `a4` output, 1: one-hot output for code 11.
- `busy` output, 1: high when the FSM is not in IDLE or the FIFO is non-empty.
- `count` output, `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.

## Operation
- **Code mapping**, with `x` as MSB: `{x,y}` = 00→`a1`, 01→`a2`, 10→`a3`, 11→`a4`. This is the exact inverse of `priority_coder`.
- **Output invariant:** at most one of `a1..a4` is high in any cycle.
- **FSM states:**
  - IDLE: outputs 0. If FIFO non-empty: pop, load the one-hot register, load the hold counter with `HOLD_CYCLES-1`, go to HOLD.
  - HOLD: one-hot held. Counter decrements each cycle; at 0 go to GAP.
  - GAP: outputs 0 for exactly one cycle. If FIFO non-empty: pop and go to HOLD directly. Otherwise go to IDLE.
- **Hold counter:** 8 bits, so no wrap for legal `HOLD_CYCLES`. `HOLD_CYCLES=1` gives a single-cycle pulse followed by a gap.
- **FIFO full:** `in_ready`=0 and incoming `in_valid` is ignored. No overwrite, no error flag.
- **FIFO empty:** no pop. The FSM stays in IDLE, or GAP→IDLE.
- **Simultaneous push and pop:** allowed whenever not full. `count` is unchanged.
- **Push into an empty FIFO while IDLE:** the code is written at edge E, popped at E+1, and is not bypassed.
- **Pointers:** `$clog2(FIFO_DEPTH)` bits, wrap naturally. Full/empty are derived from `count`.
- **Reset values** (asynchronous, immediate, including mid-HOLD):
  - `a1..a4`=0, `busy`=0, `count`=0.
  - FIFO pointers=0, FSM=IDLE, hold counter=0.
  - `in_ready`=1 after reset is released.
  - Buffered codes are discarded.

## Timing
- All outputs are registered, except `in_ready`, which is a combinational decode of `count`.
- **Latency:** a code accepted at edge E, with FIFO empty and FSM idle, drives its one-hot output high after edge E+1.
- **Pulse length:** the output stays high for exactly `HOLD_CYCLES` cycles, then is 0 for exactly 1 cycle.
- **Back-to-back codes:** output period is `HOLD_CYCLES+1` cycles.
- **`in_ready`:** updates in the cycle after the edge that fills or drains the last slot.

## Structure
- **Package `coder_pkg`:**
  - `code_t` (logic [1:0]).
  - Constants `CODE_A1`=2'b00 through `CODE_A4`=2'b11.
  - Enum `dec_state_t` {IDLE, HOLD, GAP}.
  - Function `code_to_onehot(code_t)` returning [3:0] in order {a4,a3,a2,a1}.
- **Sub-module `code_fifo`:** parameterised synchronous FIFO with async reset.
  - Ports: push, pop, din, dout, count, full, empty.
  - `dout` is first-word-valid, combinational from the read pointer.
- **Top level:** FSM, hold counter and output register.

## Test plan
- **Reset then single code:** `rst` pulse, then `{x,y}`=10 with `in_valid` for 1 cycle → `a3`=1 starting at E+1 for 4 cycles, then all 0; `busy` falls after GAP.
- **Burst of four:** codes 00, 01, 10, 11 on consecutive cycles → `count` reaches 3 with no stall; outputs `a1`, `a2`, `a3`, `a4` each 4 cycles, separated by one zero cycle; total 20 cycles from first output.
- **Overflow:** 6 back-to-back `in_valid` codes 11,11,11,11,00,01 with `HOLD_CYCLES`=4 → FIFO fills; `in_ready`=0 blocks at least the 6th code; only accepted codes appear, in order; never two outputs high at once.
- **Reset mid-operation:** assert `rst` during HOLD of `a2` with 2 codes queued → `a1..a4`=0 immediately (async), `count`=0; after release nothing is emitted.
- **`HOLD_CYCLES`=1 loop-back:** drive `priority_coder` through all 4 inputs and feed `{x,y}` in → each `a_n` reproduced as a 1-cycle pulse, 2-cycle period, matching the stimulus order.
